// File: rtl/alu.sv
// 8-bit ALU with registered result and flag byte, one cycle of latency.
// Flag byte layout: N V - B D I Z C; flags an operation does not name pass through from P.
module alu (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU,
  input  logic [7:0] P,
  input  logic [2:0] OP,
  output logic [7:0] AR,
  output logic [7:0] AF
);

  typedef enum logic [3:0] {
    OP_ORA  = 4'd0,
    OP_AND  = 4'd1,
    OP_EOR  = 4'd2,
    OP_ADC  = 4'd3,
    OP_STA  = 4'd4,
    OP_LDA  = 4'd5,
    OP_CMP  = 4'd6,
    OP_SBC  = 4'd7,
    OP_FLAG = 4'd12,
    OP_BIT  = 4'd13,
    OP_DEC  = 4'd14,
    OP_INC  = 4'd15
  } alu_op_e;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  logic [8:0] add_sum;
  logic [8:0] sub_sum;
  logic [8:0] cmp_diff;
  logic [7:0] result;
  logic [7:0] flags;
  logic       set_nz;

  // SBC reuses the adder form A + ~B + C, so carry out means "no borrow".
  assign add_sum  = {1'b0, A} + {1'b0, B} + {8'b0, P[FLAG_C]};
  assign sub_sum  = {1'b0, A} + {1'b0, ~B} + {8'b0, P[FLAG_C]};
  assign cmp_diff = {1'b0, A} + {1'b0, ~B} + 9'd1;

  always_comb begin
    result = A;
    flags  = P;
    set_nz = 1'b0;
    case (alu_op_e'(ALU))
      OP_ORA: begin
        result = A | B;
        set_nz = 1'b1;
      end
      OP_AND: begin
        result = A & B;
        set_nz = 1'b1;
      end
      OP_EOR: begin
        result = A ^ B;
        set_nz = 1'b1;
      end
      OP_ADC: begin
        result        = add_sum[7:0];
        flags[FLAG_C] = add_sum[8];
        flags[FLAG_V] = (A[7] == B[7]) && (add_sum[7] != A[7]);
        set_nz        = 1'b1;
      end
      OP_SBC: begin
        result        = sub_sum[7:0];
        flags[FLAG_C] = sub_sum[8];
        flags[FLAG_V] = (A[7] != B[7]) && (sub_sum[7] != A[7]);
        set_nz        = 1'b1;
      end
      OP_LDA: begin
        result = B;
        set_nz = 1'b1;
      end
      OP_CMP: begin
        flags[FLAG_C] = cmp_diff[8];
        flags[FLAG_N] = cmp_diff[7];
        flags[FLAG_Z] = (A == B);
      end
      OP_FLAG: begin
        case (OP)
          3'b000:  flags[FLAG_C] = 1'b0;
          3'b001:  flags[FLAG_C] = 1'b1;
          3'b010:  flags[FLAG_I] = 1'b0;
          3'b011:  flags[FLAG_I] = 1'b1;
          3'b101:  flags[FLAG_V] = 1'b0;
          3'b110:  flags[FLAG_D] = 1'b0;
          3'b111:  flags[FLAG_D] = 1'b1;
          default: flags = P;
        endcase
      end
      OP_BIT: begin
        flags[FLAG_Z] = ((A & B) == 8'h00);
        flags[FLAG_N] = B[7];
        flags[FLAG_V] = B[6];
      end
      OP_DEC: begin
        result = A - 8'd1;
        set_nz = 1'b1;
      end
      OP_INC: begin
        result = A + 8'd1;
        set_nz = 1'b1;
      end
      default: begin
        result = A;
        flags  = P;
      end
    endcase
    if (set_nz) begin
      flags[FLAG_N] = result[7];
      flags[FLAG_Z] = (result == 8'h00);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      AR <= 8'h00;
      AF <= 8'h00;
    end else begin
      AR <= result;
      AF <= flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset behaviour and randomized
// operations compared against an arithmetic reference model.
module tb_alu;

  logic       CLK;
  logic       RST;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU;
  logic [7:0] P;
  logic [2:0] OP;
  logic [7:0] AR;
  logic [7:0] AF;

  int compared;
  int mismatched;

  alu dut (
    .CLK(CLK),
    .RST(RST),
    .A(A),
    .B(B),
    .ALU(ALU),
    .P(P),
    .OP(OP),
    .AR(AR),
    .AF(AF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: signed/unsigned integer arithmetic decides carry and overflow.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op_code, input logic [7:0] p,
                                        input logic [2:0] sub);
    int ua, ub, sa, sb, cin, t, s;
    logic [7:0] r;
    logic [7:0] f;
    bit nz;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    cin = int'(p[0]);
    r = a;
    f = p;
    nz = 1'b0;
    case (op_code)
      4'd0: begin r = a | b; nz = 1'b1; end
      4'd1: begin r = a & b; nz = 1'b1; end
      4'd2: begin r = a ^ b; nz = 1'b1; end
      4'd3: begin
        t = ua + ub + cin;
        s = sa + sb + cin;
        r = 8'(t);
        f[0] = (t > 255);
        f[6] = (s > 127) || (s < -128);
        nz = 1'b1;
      end
      4'd7: begin
        t = ua - ub - (1 - cin);
        s = sa - sb - (1 - cin);
        r = 8'(t);
        f[0] = (t >= 0);
        f[6] = (s > 127) || (s < -128);
        nz = 1'b1;
      end
      4'd5: begin r = b; nz = 1'b1; end
      4'd6: begin
        t = (ua - ub + 256) % 256;
        f[0] = (ua >= ub);
        f[7] = (t >= 128);
        f[1] = (ua == ub);
      end
      4'd12: begin
        case (sub)
          3'd0: f[0] = 1'b0;
          3'd1: f[0] = 1'b1;
          3'd2: f[2] = 1'b0;
          3'd3: f[2] = 1'b1;
          3'd5: f[6] = 1'b0;
          3'd6: f[3] = 1'b0;
          3'd7: f[3] = 1'b1;
          default: f = p;
        endcase
      end
      4'd13: begin
        f[1] = ((a & b) == 8'h00);
        f[7] = b[7];
        f[6] = b[6];
      end
      4'd14: begin r = 8'((ua + 255) % 256); nz = 1'b1; end
      4'd15: begin r = 8'((ua + 1) % 256); nz = 1'b1; end
      default: begin r = a; f = p; end
    endcase
    if (nz) begin
      f[7] = (int'(r) >= 128);
      f[1] = (r == 8'h00);
    end
    return {r, f};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic applyStimulus(input logic rst, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op_code, input logic [7:0] p,
                               input logic [2:0] sub);
    RST = rst;
    A   = a;
    B   = b;
    ALU = op_code;
    P   = p;
    OP  = sub;
    @(posedge CLK);
    #1;
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op_code, input logic [7:0] p, input logic [2:0] sub,
                          input logic [7:0] exp_ar, input logic [7:0] exp_af);
    applyStimulus(1'b0, a, b, op_code, p, sub);
    checkOutput({tag, "_AR"}, AR, exp_ar);
    checkOutput({tag, "_AF"}, AF, exp_af);
  endtask

  initial begin
    logic [15:0] exp;
    logic [7:0] ra, rb, rp;
    logic [3:0] rop;
    logic [2:0] rsub;
    compared = 0;
    mismatched = 0;
    RST = 1'b1;
    A = 8'h00; B = 8'h00; ALU = 4'd0; P = 8'h00; OP = 3'd0;
    #1;

    // Reset overrides an operation that would otherwise give nonzero outputs.
    applyStimulus(1'b1, 8'h12, 8'hFF, 4'd5, 8'hFF, 3'd0);
    checkOutput("reset_AR", AR, 8'h00);
    checkOutput("reset_AF", AF, 8'h00);
    applyStimulus(1'b1, 8'h34, 8'h80, 4'd3, 8'h3C, 3'd0);
    checkOutput("reset_hold_AR", AR, 8'h00);
    checkOutput("reset_hold_AF", AF, 8'h00);

    // First edge after reset release loads a real result.
    directed("post_reset_lda", 8'h00, 8'h80, 4'd5, 8'h30, 3'd0, 8'h80, 8'hB0);

    directed("adc_50_50",   8'h50, 8'h50, 4'd3,  8'h00, 3'd0, 8'hA0, 8'hC0);
    directed("sbc_00_01",   8'h00, 8'h01, 4'd7,  8'h01, 3'd0, 8'hFF, 8'h80);
    directed("sbc_80_01",   8'h80, 8'h01, 4'd7,  8'h01, 3'd0, 8'h7F, 8'h41);
    directed("cmp_eq",      8'h40, 8'h40, 4'd6,  8'h00, 3'd0, 8'h40, 8'h03);
    directed("cmp_lt",      8'h10, 8'h20, 4'd6,  8'h00, 3'd0, 8'h10, 8'h80);
    directed("bit_0f_c0",   8'h0F, 8'hC0, 4'd13, 8'h00, 3'd0, 8'h0F, 8'hC2);
    directed("sec",         8'h00, 8'h00, 4'd12, 8'h00, 3'd1, 8'h00, 8'h01);
    directed("clv",         8'h00, 8'h00, 4'd12, 8'h40, 3'd5, 8'h00, 8'h00);
    directed("flag_nop",    8'h5A, 8'h00, 4'd12, 8'hFF, 3'd4, 8'h5A, 8'hFF);
    directed("dec_wrap",    8'h00, 8'h00, 4'd14, 8'h01, 3'd0, 8'hFF, 8'h81);
    directed("inc_wrap",    8'hFF, 8'h00, 4'd15, 8'h00, 3'd0, 8'h00, 8'h02);
    directed("sta_pass",    8'h9C, 8'h11, 4'd4,  8'h34, 3'd0, 8'h9C, 8'h34);
    directed("unused_9",    8'h77, 8'h11, 4'd9,  8'hE5, 3'd3, 8'h77, 8'hE5);
    directed("ora_pass_b",  8'h01, 8'h02, 4'd0,  8'h30, 3'd0, 8'h03, 8'h30);

    // Reset in the middle of a stream, then immediate recovery.
    directed("mid_adc",     8'h01, 8'h01, 4'd3,  8'h00, 3'd0, 8'h02, 8'h00);
    applyStimulus(1'b1, 8'h50, 8'h50, 4'd3, 8'h00, 3'd0);
    checkOutput("mid_reset_AR", AR, 8'h00);
    checkOutput("mid_reset_AF", AF, 8'h00);
    directed("mid_ora_zero", 8'h00, 8'h00, 4'd0, 8'h00, 3'd0, 8'h00, 8'h02);

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rp   = 8'($urandom);
      rop  = 4'($urandom);
      rsub = 3'($urandom);
      exp  = model(ra, rb, rop, rp, rsub);
      applyStimulus(1'b0, ra, rb, rop, rp, rsub);
      checkOutput($sformatf("rand%0d_op%0d_AR", i, rop), AR, exp[15:8]);
      checkOutput($sformatf("rand%0d_op%0d_AF", i, rop), AF, exp[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST  input  1  reset; synchronous, active-high.
REQ-003 A  input  8  operand A (accumulator/X/Y/0 as selected by the CPU).
REQ-004 B  input  8  operand B (memory data/A/X/Y/S).
REQ-005 ALU  input  4  operation code.
REQ-006 P  input  8  current flags: bit7 N, 6 V, 5 unused, 4 B, 3 D, 2 I, 1 Z, 0 C.
REQ-007 OP  input  3  opcode[7:5], sub-selector for flag ops.
REQ-008 AR  output  8  registered result.
REQ-009 AF  output  8  registered new flag byte.

Function
REQ-010 Latency: one cycle; on each CLK rise with RST=0, AR/AF SHALL load the result computed from the current inputs; no enable, no handshake.
REQ-011 Flags not named for an operation SHALL pass through unchanged from P, including bits 5 and 4.
REQ-012 "NZ" SHALL mean N = result bit7 and Z = (result == 00).
REQ-013 ALU=0 ORA: R = A|B; NZ.
REQ-014 ALU=1 AND: R = A&B; NZ.
REQ-015 ALU=2 EOR: R = A^B; NZ.
REQ-016 ALU=3 ADC: 9-bit sum A+B+P.C; R = sum[7:0]; C = sum[8]; V = (A7==B7)&(R7!=A7); NZ; binary only, D ignored.
REQ-017 ALU=7 SBC: sum = A+~B+P.C; R = sum[7:0]; C = sum[8] (1 = no borrow); V = (A7!=B7)&(R7!=A7); NZ; binary only.
REQ-018 ALU=4 STA: R = A; AF = P.
REQ-019 ALU=5 LDA/transfer: R = B; NZ.
REQ-020 ALU=6 CMP: D = A-B (8 bits); R = A; C = (A >= B unsigned); N = D7; Z = (A == B); V unchanged.
REQ-021 ALU=12 flag op: R = A; by OP: 000 C=0, 001 C=1, 010 I=0, 011 I=1, 101 V=0, 110 D=0, 111 D=1, 100 no change.
REQ-022 ALU=13 BIT: R = A; Z = ((A&B)==0); N = B7; V = B6.
REQ-023 ALU=14 DEC: R = A-1 mod 256; NZ; C,V unchanged; 00 wraps to FF.
REQ-024 ALU=15 INC: R = A+1 mod 256; NZ; C,V unchanged; FF wraps to 00.
REQ-025 ALU=8..11 (unused): R = A; AF = P.
REQ-026 AR SHALL equal R; AF SHALL equal P with the above modifications.

Reset
REQ-027 RST=1 at a CLK rise SHALL force AR=00, AF=00, overriding any operation in that cycle; with RST held, outputs stay 00.
REQ-028 First rising edge after RST falls SHALL load the normal result; no extra idle cycle.

Verification
REQ-029 ADC A=50 B=50 P=00 -> next edge AR=A0, AF=C0 (N=1, V=1, Z=0, C=0).
REQ-030 SBC A=00 B=01 P=01 -> AR=FF, AF=80 (C=0, N=1, V=0); SBC A=80 B=01 P=01 -> AR=7F, AF=41 (V=1, C=1).
REQ-031 CMP A=40 B=40 P=00 -> AR=40, AF=03; CMP A=10 B=20 P=00 -> AR=10, AF=80.
REQ-032 BIT A=0F B=C0 P=00 -> AR=0F, AF=C2; flag op ALU=12 OP=001 P=00 -> AF=01; OP=101 P=40 -> AF=00.
REQ-033 DEC A=00 P=01 -> AR=FF, AF=81; INC A=FF P=00 -> AR=00, AF=02.
REQ-034 Reset mid-stream: ADC result held, RST=1 for one edge -> AR=00, AF=00; RST=0 with ORA A=00 B=00 P=00 -> AR=00, AF=02.
